fll_cfg_seq: RTL
================

Name: fll_cfg_seq

Overview:
- Multi-channel FLL configuration sequencer. It replaces the single-FLL fixed control unit in the clock-generation subsystem.
- On command, it writes a register table into one of N_CH FLL macros over the CFGREQ/CFGACK four-phase port, then waits for lock.
- It synchronises every FLL lock and ack input and tracks loss-of-lock per channel.
- Runs entirely in the reference-clock domain.

Parameters:
- N_CH, 2: number of FLL channels.
- CH_W, 1: width of channel select; 2**CH_W >= N_CH.
- ADDR_W, 2: FLL config address width.
- DATA_W, 32: FLL config data width.
- N_REGS, 4: registers written per sequence, at addresses 0..N_REGS-1. N_REGS <= 2**ADDR_W.
- TO_W, 8: handshake timeout counter width. Timeout = 2**TO_W-1 cycles.
- LK_W, 12: lock-wait counter width. Timeout = 2**LK_W-1 cycles.

Ports:
- ref_clk, in, 1: reference clock; the only clock.
- rst, in, 1: asynchronous reset, active-high.
- cfg_start, in, 1: one-cycle start command.
- cfg_ch, in, CH_W: target channel, sampled with cfg_start.
- cfg_data, in, N_REGS*DATA_W: register table. Slot i goes to address i. Sampled into a shadow copy on an accepted cfg_start.
- busy, out, 1: sequence in progress.
- done, out, 1: one-cycle pulse; sequence completed and lock seen.
- err, out, 1: one-cycle pulse; sequence aborted.
- err_code, out, 2: cause of last error. 1 = handshake timeout, 2 = lock timeout, 3 = bad channel. Held until the next accepted start.
- fll_cfgreq, out, N_CH: per-channel config request.
- fll_cfgack, in, N_CH: per-channel ack; asynchronous.
- fll_cfgweb, out, 1: shared write-enable, active-low.
- fll_cfgad, out, ADDR_W: shared address.
- fll_cfgd, out, DATA_W: shared write data.
- fll_lock, in, N_CH: per-channel lock; asynchronous.
- lock_sts, out, N_CH: synchronised lock.
- lock_lost, out, N_CH: sticky, set on a 1->0 of lock_sts.
- lock_clr, in, N_CH: clears the matching lock_lost bit.

Behaviour:
- Reset values: all outputs 0 except fll_cfgweb = 1. FSM in IDLE; shadow table, counters and synchronisers cleared.
- fll_cfgack and fll_lock each pass through a 2-flop synchroniser (ack_s, lock_s). lock_sts = lock_s.
- lock_lost[i] set when lock_s[i] was 1 the previous cycle and is 0 now. Cleared by lock_clr[i]; if set and clear coincide, set wins. Operates independently of the FSM.
- FSM states: IDLE, REQ, ACKLO, LOCKW.
- IDLE: on cfg_start:
  - cfg_ch >= N_CH: err pulses the next cycle, err_code = 3, stay IDLE.
  - Otherwise: latch ch and cfg_data, idx = 0, clear err_code, go to REQ; busy = 1 from the next cycle.
- REQ:
  - Drive fll_cfgreq[ch] = 1, fll_cfgweb = 0, fll_cfgad = idx, fll_cfgd = slot idx.
  - On ack_s[ch] = 1: drop req, restore web = 1, go to ACKLO.
  - Address, data and web are held stable for as long as req is high.
- ACKLO: on ack_s[ch] = 0:
  - idx == N_REGS-1: go to LOCKW.
  - Otherwise: idx+1, go to REQ.
  - Minimum 1 idle cycle between requests.
- LOCKW: on lock_s[ch] = 1: done pulses, busy drops the same cycle, go to IDLE.
- Timeouts:
  - The handshake timer resets on each REQ or ACKLO entry. Reaching 2**TO_W-1 aborts: req = 0, web = 1, err pulse, err_code = 1, IDLE.
  - The lock timer works the same way in LOCKW: err_code = 2, IDLE.
- cfg_start while busy is ignored; no error is raised.
- Only fll_cfgreq[ch] can ever be high; other channels stay 0.
- Async reset mid-sequence: req drops immediately. No partial state persists.
- Minimum sequence latency from cfg_start to done, assuming instantaneous ack and lock: 1 + N_REGS*(2 sync + 1 + 2 sync + 1) + 2 cycles.

Test Plan:
- Clean sequence: ch = 1, table {A0, A1, A2, A3}, ack responder with 3-cycle delay, lock rising 50 cycles after the last write -> four writes seen at addresses 0..3 in order. fll_cfgreq[0] stays 0. done pulses once; err never.
- Handshake timeout: ack held 0 -> err pulses after exactly 255 cycles in REQ, err_code = 1, fll_cfgreq = 0, busy = 0.
- Lock timeout: acks normal, lock held 0 -> err after 4095 cycles in LOCKW, err_code = 2.
- Bad channel with N_CH = 3, CH_W = 2: cfg_ch = 3 -> err pulses the next cycle, err_code = 3, no request issued. Repeat with cfg_start asserted while busy -> ignored, sequence unaffected.
- Loss of lock: lock 1 -> 0 on ch 0 -> lock_lost[0] = 1 three cycles later and stays set. Pulse lock_clr[0] together with a new falling edge -> bit remains 1.
- Reset mid-REQ: assert rst while fll_cfgreq[1] = 1 -> req drops asynchronously, web = 1, busy = 0. A new start after release runs normally.

Source files
------------

// File: rtl/fll_cfg_seq.sv
// fll_cfg_seq: writes a shadowed register table into one of N_CH FLLs over a four-phase
// req/ack port, waits for lock, and tracks synchronised lock and sticky loss-of-lock.
module fll_cfg_seq #(
  parameter int N_CH   = 2,
  parameter int CH_W   = 1,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int N_REGS = 4,
  parameter int TO_W   = 8,
  parameter int LK_W   = 12
) (
  input  logic                     ref_clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [N_REGS*DATA_W-1:0] cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [N_CH-1:0]          fll_cfgreq,
  input  logic [N_CH-1:0]          fll_cfgack,
  output logic                     fll_cfgweb,
  output logic [ADDR_W-1:0]        fll_cfgad,
  output logic [DATA_W-1:0]        fll_cfgd,
  input  logic [N_CH-1:0]          fll_lock,
  output logic [N_CH-1:0]          lock_sts,
  output logic [N_CH-1:0]          lock_lost,
  input  logic [N_CH-1:0]          lock_clr
);
  localparam int TW = LK_W > TO_W ? LK_W : TO_W;
  localparam logic [TW-1:0] TO_MAX = TW'((64'd1 << TO_W) - 64'd1);
  localparam logic [TW-1:0] LK_MAX = TW'((64'd1 << LK_W) - 64'd1);
  typedef enum logic [1:0] {IDLE, REQ, ACKLO, LOCKW} state_t;
  state_t                  state;
  logic [N_CH-1:0]         ack_m, ack_s, lock_m, lock_s, lock_d;
  logic [CH_W-1:0]         ch;
  logic [ADDR_W-1:0]       idx, nidx;
  logic [N_REGS*DATA_W-1:0] shadow;
  logic [TW-1:0]           tmr;
  logic [1:0]              abort_code;
  logic                    last, bad_ch;
  assign lock_sts = lock_s;
  assign nidx     = idx + 1'b1;
  assign last     = idx == ADDR_W'(N_REGS - 1);
  assign bad_ch   = 32'(cfg_ch) >= N_CH;
  // The timer is reloaded with 1 on every state entry, so hitting the max means max cycles spent there
  assign abort_code = (state == REQ && !ack_s[ch] && tmr == TO_MAX) ? 2'd1 :
                      (state == ACKLO && ack_s[ch] && tmr == TO_MAX) ? 2'd1 :
                      (state == LOCKW && !lock_s[ch] && tmr == LK_MAX) ? 2'd2 : 2'd0;
  always_ff @(posedge ref_clk or posedge rst)
    if (rst) begin
      ack_m     <= '0;
      ack_s     <= '0;
      lock_m    <= '0;
      lock_s    <= '0;
      lock_d    <= '0;
      lock_lost <= '0;
    end else begin
      {ack_s, ack_m}   <= {ack_m, fll_cfgack};
      {lock_s, lock_m} <= {lock_m, fll_lock};
      lock_d           <= lock_s;
      lock_lost        <= (lock_lost & ~lock_clr) | (lock_d & ~lock_s);
    end
  always_ff @(posedge ref_clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      ch         <= '0;
      idx        <= '0;
      shadow     <= '0;
      tmr        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      fll_cfgreq <= '0;
      fll_cfgweb <= 1'b1;
      fll_cfgad  <= '0;
      fll_cfgd   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      tmr  <= tmr + 1'b1;
      case (state)
        IDLE: if (cfg_start) begin
          if (bad_ch) begin
            err      <= 1'b1;
            err_code <= 2'd3;
          end else begin
            state      <= REQ;
            ch         <= cfg_ch;
            shadow     <= cfg_data;
            idx        <= '0;
            err_code   <= 2'd0;
            busy       <= 1'b1;
            tmr        <= TW'(1);
            fll_cfgreq <= N_CH'(1) << cfg_ch;
            fll_cfgweb <= 1'b0;
            fll_cfgad  <= '0;
            fll_cfgd   <= cfg_data[DATA_W-1:0];
          end
        end
        REQ: if (ack_s[ch]) begin
          state      <= ACKLO;
          tmr        <= TW'(1);
          fll_cfgreq <= '0;
          fll_cfgweb <= 1'b1;
        end
        ACKLO: if (!ack_s[ch]) begin
          tmr <= TW'(1);
          if (last) state <= LOCKW;
          else begin
            state      <= REQ;
            idx        <= nidx;
            fll_cfgreq <= N_CH'(1) << ch;
            fll_cfgweb <= 1'b0;
            fll_cfgad  <= nidx;
            fll_cfgd   <= shadow[int'(nidx)*DATA_W +: DATA_W];
          end
        end
        LOCKW: if (lock_s[ch]) begin
          state <= IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (abort_code != 2'd0) begin
        state      <= IDLE;
        busy       <= 1'b0;
        err        <= 1'b1;
        err_code   <= abort_code;
        fll_cfgreq <= '0;
        fll_cfgweb <= 1'b1;
      end
    end
endmodule
